// File: rtl/fetch_pred_stage.sv
// Fetch stage with a direct-mapped BTB and 2-bit direction counters.
// Holds the PC, predicts the next PC and registers the fetched word for decode.
module fetch_pred_stage #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter logic [1:0]      CTR_INIT    = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_f,
  input  logic            flush_d,
  input  logic            res_valid_e,
  input  logic            res_taken_e,
  input  logic [XLEN-1:0] res_pc_e,
  input  logic [XLEN-1:0] res_target_e,
  input  logic            res_pred_taken_e,
  input  logic [XLEN-1:0] res_pred_target_e,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d,
  output logic            pred_taken_d,
  output logic [XLEN-1:0] pred_target_d,
  output logic            valid_d,
  output logic            mispredict_o,
  output logic [31:0]     mispred_cnt_o
);

  localparam int unsigned IW = $clog2(BTB_ENTRIES);
  localparam int unsigned TW = XLEN - IW - 2;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d_nxt;

  logic [BTB_ENTRIES-1:0] btb_v_q;
  logic [TW-1:0]          btb_tag_q [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_tgt_q [BTB_ENTRIES];
  logic [1:0]             btb_ctr_q [BTB_ENTRIES];

  logic [IW-1:0]   l_idx;
  logic [TW-1:0]   l_tag;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic [XLEN-1:0] pc_plus4;

  logic [IW-1:0]   u_idx;
  logic [TW-1:0]   u_tag;
  logic            u_hit;
  logic [1:0]      u_ctr;
  logic [1:0]      u_ctr_nxt;

  logic [XLEN-1:0] redirect;
  logic            dir_wrong;
  logic            tgt_wrong;

  assign imem_addr_o = pc_q;
  assign pc_plus4    = pc_q + XLEN'(4);

  // Lookup reads the registered arrays, so a same-cycle update is not seen.
  assign l_idx       = pc_q[IW+1:2];
  assign l_tag       = pc_q[XLEN-1:IW+2];
  assign pred_taken  = btb_v_q[l_idx] &&
                       (btb_tag_q[l_idx] == l_tag) &&
                       btb_ctr_q[l_idx][1];
  assign pred_target = btb_tgt_q[l_idx];

  assign u_idx = res_pc_e[IW+1:2];
  assign u_tag = res_pc_e[XLEN-1:IW+2];
  assign u_hit = btb_v_q[u_idx] && (btb_tag_q[u_idx] == u_tag);
  assign u_ctr = btb_ctr_q[u_idx];

  // Saturating 2-bit counter step toward the resolved direction.
  always_comb begin
    u_ctr_nxt = u_ctr;
    if (res_taken_e) begin
      if (u_ctr != 2'b11) u_ctr_nxt = u_ctr + 2'd1;
    end else begin
      if (u_ctr != 2'b00) u_ctr_nxt = u_ctr - 2'd1;
    end
  end

  assign dir_wrong = res_taken_e != res_pred_taken_e;
  assign tgt_wrong = res_taken_e & res_pred_taken_e &
                     (res_target_e != res_pred_target_e);

  // Resolution is ignored entirely while reset is held.
  assign mispredict_o = ~rst & res_valid_e & (dir_wrong | tgt_wrong);
  assign redirect     = res_taken_e ? res_target_e
                                    : res_pc_e + XLEN'(4);

  // Next-PC select: redirect beats stall beats prediction.
  always_comb begin
    pc_d_nxt = pc_plus4;
    priority case (1'b1)
      mispredict_o: pc_d_nxt = redirect;
      stall_f:      pc_d_nxt = pc_q;
      pred_taken:   pc_d_nxt = pred_target;
      default:      pc_d_nxt = pc_plus4;
    endcase
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d_nxt;
  end

  // BTB training; runs regardless of stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_v_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
        btb_ctr_q[i] <= CTR_INIT;
      end
    end else if (res_valid_e) begin
      if (u_hit) begin
        btb_ctr_q[u_idx] <= u_ctr_nxt;
        if (res_taken_e) btb_tgt_q[u_idx] <= res_target_e;
      end else if (res_taken_e) begin
        btb_v_q[u_idx]   <= 1'b1;
        btb_tag_q[u_idx] <= u_tag;
        btb_tgt_q[u_idx] <= res_target_e;
        btb_ctr_q[u_idx] <= 2'b10;
      end
    end
  end

  // Decode register: kill on redirect/flush, else hold on stall or load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_d       <= '0;
      pc_d          <= '0;
      pcplus4_d     <= '0;
      pred_taken_d  <= 1'b0;
      pred_target_d <= '0;
      valid_d       <= 1'b0;
    end else if (mispredict_o || flush_d) begin
      valid_d <= 1'b0;
    end else if (!stall_f) begin
      instr_d       <= imem_rdata_i;
      pc_d          <= pc_q;
      pcplus4_d     <= pc_plus4;
      pred_taken_d  <= pred_taken;
      pred_target_d <= pred_target;
      valid_d       <= 1'b1;
    end
  end

  // Saturating mispredict counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispred_cnt_o <= '0;
    end else if (mispredict_o && (mispred_cnt_o != 32'hFFFF_FFFF)) begin
      mispred_cnt_o <= mispred_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_pred_stage.sv
// Directed bench for fetch_pred_stage.
// Linear sequence of steps, each checked against hand-derived values.
module tb_fetch_pred_stage;

  logic        clk;
  logic        rst;
  logic        stall_f;
  logic        flush_d;
  logic        res_valid_e;
  logic        res_taken_e;
  logic [31:0] res_pc_e;
  logic [31:0] res_target_e;
  logic        res_pred_taken_e;
  logic [31:0] res_pred_target_e;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        pred_taken_d;
  logic [31:0] pred_target_d;
  logic        valid_d;
  logic        mispredict_o;
  logic [31:0] mispred_cnt_o;

  int checks = 0;
  int errors = 0;

  fetch_pred_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stall_f           (stall_f),
    .flush_d           (flush_d),
    .res_valid_e       (res_valid_e),
    .res_taken_e       (res_taken_e),
    .res_pc_e          (res_pc_e),
    .res_target_e      (res_target_e),
    .res_pred_taken_e  (res_pred_taken_e),
    .res_pred_target_e (res_pred_target_e),
    .imem_addr_o       (imem_addr_o),
    .imem_rdata_i      (imem_rdata_i),
    .instr_d           (instr_d),
    .pc_d              (pc_d),
    .pcplus4_d         (pcplus4_d),
    .pred_taken_d      (pred_taken_d),
    .pred_target_d     (pred_target_d),
    .valid_d           (valid_d),
    .mispredict_o      (mispredict_o),
    .mispred_cnt_o     (mispred_cnt_o)
  );

  assign imem_rdata_i = imem_addr_o ^ 32'hDEAD_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic resolve(input logic        taken,
                         input logic [31:0] pc,
                         input logic [31:0] tgt,
                         input logic        ptaken,
                         input logic [31:0] ptgt);
    res_valid_e       = 1'b1;
    res_taken_e       = taken;
    res_pc_e          = pc;
    res_target_e      = tgt;
    res_pred_taken_e  = ptaken;
    res_pred_target_e = ptgt;
  endtask

  task automatic idle_res();
    res_valid_e = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    stall_f = 1'b0;
    flush_d = 1'b0;
    res_valid_e = 1'b0;
    res_taken_e = 1'b0;
    res_pc_e = '0;
    res_target_e = '0;
    res_pred_taken_e = 1'b0;
    res_pred_target_e = '0;

    #1 rst = 1'b1;
    #2;
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", {31'd0, valid_d}, 32'd0);
    chk("rst_pc_d", pc_d, 32'h0);
    chk("rst_cnt", mispred_cnt_o, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("f0_addr", imem_addr_o, 32'h0);
    chk("f0_valid", {31'd0, valid_d}, 32'd0);

    tick();
    chk("f1_addr", imem_addr_o, 32'h4);
    chk("f1_valid", {31'd0, valid_d}, 32'd1);
    chk("f1_pc_d", pc_d, 32'h0);
    chk("f1_instr", instr_d, 32'hDEAD_0000);
    chk("f1_pc4", pcplus4_d, 32'h4);
    chk("f1_pt", {31'd0, pred_taken_d}, 32'd0);

    tick();
    chk("f2_addr", imem_addr_o, 32'h8);
    chk("f2_pc_d", pc_d, 32'h4);

    stall_f = 1'b1;
    repeat (3) begin
      tick();
      chk("stall_addr", imem_addr_o, 32'h8);
      chk("stall_pc_d", pc_d, 32'h4);
      chk("stall_instr", instr_d, 32'hDEAD_0004);
      chk("stall_valid", {31'd0, valid_d}, 32'd1);
    end

    stall_f = 1'b0;
    tick();
    chk("f3_addr", imem_addr_o, 32'hC);
    chk("f3_pc_d", pc_d, 32'h8);

    stall_f = 1'b1;
    resolve(1'b1, 32'h10, 32'h40, 1'b0, 32'h0);
    #1;
    chk("mp1_comb", {31'd0, mispredict_o}, 32'd1);
    tick();
    chk("mp1_addr", imem_addr_o, 32'h40);
    chk("mp1_valid", {31'd0, valid_d}, 32'd0);
    chk("mp1_cnt", mispred_cnt_o, 32'd1);

    stall_f = 1'b0;
    resolve(1'b0, 32'hC, 32'h0, 1'b1, 32'h10);
    #1;
    chk("rd1_comb", {31'd0, mispredict_o}, 32'd1);
    tick();
    chk("rd1_addr", imem_addr_o, 32'h10);
    chk("rd1_cnt", mispred_cnt_o, 32'd2);
    idle_res();

    tick();
    chk("hit_addr", imem_addr_o, 32'h40);
    chk("hit_pc_d", pc_d, 32'h10);
    chk("hit_pt", {31'd0, pred_taken_d}, 32'd1);
    chk("hit_ptgt", pred_target_d, 32'h40);
    chk("hit_pc4", pcplus4_d, 32'h14);
    chk("hit_valid", {31'd0, valid_d}, 32'd1);

    resolve(1'b0, 32'h10, 32'h40, 1'b1, 32'h40);
    tick();
    chk("nt1_addr", imem_addr_o, 32'h14);
    chk("nt1_cnt", mispred_cnt_o, 32'd3);
    tick();
    chk("nt2_addr", imem_addr_o, 32'h14);
    chk("nt2_cnt", mispred_cnt_o, 32'd4);
    resolve(1'b0, 32'hC, 32'h0, 1'b1, 32'h10);
    tick();
    chk("rd2_addr", imem_addr_o, 32'h10);
    chk("rd2_cnt", mispred_cnt_o, 32'd5);
    idle_res();
    tick();
    chk("weak_addr", imem_addr_o, 32'h14);
    chk("weak_pt", {31'd0, pred_taken_d}, 32'd0);
    chk("weak_pc_d", pc_d, 32'h10);

    resolve(1'b1, 32'h10, 32'h40, 1'b1, 32'h40);
    #1;
    chk("ok_comb", {31'd0, mispredict_o}, 32'd0);
    tick();
    chk("ok_addr", imem_addr_o, 32'h18);
    chk("ok_cnt", mispred_cnt_o, 32'd5);

    resolve(1'b0, 32'hC, 32'h0, 1'b1, 32'h10);
    tick();
    chk("rd3_addr", imem_addr_o, 32'h10);
    chk("rd3_cnt", mispred_cnt_o, 32'd6);

    resolve(1'b1, 32'h10, 32'h40, 1'b1, 32'h40);
    tick();
    chk("same_addr", imem_addr_o, 32'h14);
    chk("same_pt", {31'd0, pred_taken_d}, 32'd0);
    chk("same_pc_d", pc_d, 32'h10);
    chk("same_cnt", mispred_cnt_o, 32'd6);

    resolve(1'b0, 32'hC, 32'h0, 1'b1, 32'h10);
    tick();
    chk("rd4_addr", imem_addr_o, 32'h10);
    chk("rd4_cnt", mispred_cnt_o, 32'd7);
    idle_res();
    tick();
    chk("new_addr", imem_addr_o, 32'h40);
    chk("new_pt", {31'd0, pred_taken_d}, 32'd1);
    chk("new_ptgt", pred_target_d, 32'h40);

    flush_d = 1'b1;
    tick();
    chk("fl_addr", imem_addr_o, 32'h44);
    chk("fl_valid", {31'd0, valid_d}, 32'd0);
    flush_d = 1'b0;
    tick();
    chk("pfl_addr", imem_addr_o, 32'h48);
    chk("pfl_valid", {31'd0, valid_d}, 32'd1);
    chk("pfl_pc_d", pc_d, 32'h44);

    stall_f = 1'b1;
    resolve(1'b0, 32'hC, 32'h0, 1'b1, 32'h10);
    rst = 1'b1;
    #1;
    chk("ar_addr", imem_addr_o, 32'h0);
    chk("ar_valid", {31'd0, valid_d}, 32'd0);
    chk("ar_pc_d", pc_d, 32'h0);
    chk("ar_instr", instr_d, 32'h0);
    chk("ar_pc4", pcplus4_d, 32'h0);
    chk("ar_pt", {31'd0, pred_taken_d}, 32'd0);
    chk("ar_ptgt", pred_target_d, 32'h0);
    chk("ar_cnt", mispred_cnt_o, 32'd0);
    chk("ar_mp", {31'd0, mispredict_o}, 32'd0);
    tick();
    chk("ar_hold_addr", imem_addr_o, 32'h0);
    chk("ar_hold_cnt", mispred_cnt_o, 32'd0);

    idle_res();
    stall_f = 1'b0;
    rst = 1'b0;
    #1;
    chk("rel_addr", imem_addr_o, 32'h0);
    resolve(1'b0, 32'hC, 32'h0, 1'b1, 32'h10);
    tick();
    chk("rd5_addr", imem_addr_o, 32'h10);
    chk("rd5_cnt", mispred_cnt_o, 32'd1);
    idle_res();
    tick();
    chk("miss_addr", imem_addr_o, 32'h14);
    chk("miss_pt", {31'd0, pred_taken_d}, 32'd0);
    chk("miss_pc_d", pc_d, 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pred_stage.md
FETCH_PRED_STAGE -- requirements
Module: fetch_pred_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and address width.
REQ-002 SHALL have parameter BTB_ENTRIES, default 16, number of direct-mapped BTB entries (power of 2, ≥2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 SHALL have parameter CTR_INIT, default 2'b01, 2-bit counter value at reset.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-007 SHALL have port stall_f, input, 1, hold the PC and the decode register.
REQ-008 SHALL have port flush_d, input, 1, invalidate the decode register.
REQ-009 SHALL have ports res_valid_e (input, 1) and res_taken_e (input, 1): branch resolved this cycle, and its actual direction.
REQ-010 SHALL have ports res_pc_e and res_target_e (input, XLEN): resolved branch PC and actual target.
REQ-011 SHALL have ports res_pred_taken_e (input, 1) and res_pred_target_e (input, XLEN): the prediction made for that branch.
REQ-012 SHALL have ports imem_addr_o (output, XLEN) = current PC, and imem_rdata_i (input, 32) = combinational instruction at that address.
REQ-013 SHALL have decode outputs, all registered: instr_d (32), pc_d (XLEN), pcplus4_d (XLEN), pred_taken_d (1), pred_target_d (XLEN), valid_d (1).
REQ-014 SHALL have outputs mispredict_o (1, combinational) and mispred_cnt_o (32, registered).

Function
REQ-015 SHALL index the BTB with PC[log2(BTB_ENTRIES)+1:2] and tag it with the remaining upper PC bits; each entry holds valid, tag, target and a 2-bit counter.
REQ-016 SHALL raise pred_taken (internal) when the indexed entry is valid, its tag matches, and counter[1]=1; pred_target = entry target.
REQ-017 SHALL assert mispredict_o = res_valid_e & ((res_taken_e != res_pred_taken_e) | (res_taken_e & res_pred_taken_e & res_target_e != res_pred_target_e)).
REQ-018 SHALL set redirect = res_taken_e ? res_target_e : res_pc_e + 4 (modulo 2^XLEN).
REQ-019 SHALL select next PC by priority: mispredict_o -> redirect; else stall_f -> hold; else pred_taken -> pred_target; else PC+4.
REQ-020 SHALL, on a clock edge with mispredict_o=1 or flush_d=1, clear valid_d, regardless of stall_f.
REQ-021 SHALL otherwise, with stall_f=1, hold all decode outputs; with stall_f=0, load instr_d, pc_d, pcplus4_d, pred_taken_d, pred_target_d from the current fetch, and set valid_d=1.
REQ-022 SHALL, on res_valid_e with tag hit, update the counter by saturating increment (taken) or decrement (not taken), saturating at 3 and 0, and write target=res_target_e when taken.
REQ-023 SHALL, on res_valid_e & res_taken_e with a miss, allocate the entry: valid=1, new tag, target, counter=2'b10; a not-taken miss SHALL not allocate.
REQ-024 SHALL, when an update and a lookup hit the same index in one cycle, give the lookup the pre-update contents; the update is visible on the next cycle.
REQ-025 SHALL apply BTB updates even when stall_f=1.
REQ-026 SHALL increment mispred_cnt_o on each cycle with mispredict_o=1, saturating at 32'hFFFF_FFFF.
REQ-027 SHALL give instruction fetch-to-decode a latency of one cycle.

Reset
REQ-028 SHALL on rst=1 immediately set PC=RESET_PC, clear all BTB valid bits, set all counters to CTR_INIT, drive all decode outputs and mispred_cnt_o to 0, and keep valid_d=0.
REQ-029 SHALL ignore res_valid_e, stall_f and flush_d while rst=1, including a reset asserted mid-stall or mid-redirect; the first fetch after release SHALL be at RESET_PC.

Verification
REQ-030 SHALL verify: release reset, no stalls -> imem_addr_o = 0, 4, 8, 12 on successive cycles; valid_d=1 from cycle 2 with pc_d=0.
REQ-031 SHALL verify: resolve taken branch at PC 0x10, target 0x40, pred_taken=0 -> mispredict_o=1, next PC=0x40, valid_d=0, mispred_cnt_o=1; the next fetch of 0x10 predicts taken to 0x40.
REQ-032 SHALL verify: two not-taken resolves at 0x10 after allocation -> counter goes 2->1->0; the fetch of 0x10 then predicts PC+4=0x14.
REQ-033 SHALL verify: stall_f=1 for 3 cycles at PC 0x8 -> imem_addr_o and decode outputs are held; a mispredict during the stall still redirects and clears valid_d.
REQ-034 SHALL verify: an update and a lookup to the same index in the same cycle -> the lookup uses the old entry, and the next cycle uses the new entry.
REQ-035 SHALL verify: rst asserted mid-operation -> all outputs are 0 asynchronously, and the BTB misses for all previously allocated PCs.
